tick_gen: RTL and testbench



---
 rtl/tick_gen.sv | 188 ++++++++++++++++++
 tb/tb_tick_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tick_gen
//  Purpose  : Programmable down-counting tick generator. A loaded period is
//             counted down on enabled cycles. Reaching terminal count emits a
//             one-cycle tick. The run is either one-shot (tick + done, then
//             idle) or periodic (reload and continue). start/stop control the
//             run, en_i pauses it, and busy/done report status.
//  Option   : define TICK_GEN_TICK_CNT_EN to add tick_cnt_o, a saturating
//             count of the ticks emitted since the last accepted start.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] period_i,
    output logic             busy_o,
    output logic             tick_o,
    output logic             done_o,
    output logic [WIDTH-1:0] count_o
`ifdef TICK_GEN_TICK_CNT_EN
    ,
    output logic [WIDTH-1:0] tick_cnt_o
`endif
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // mode register values
    localparam logic C_MODE_ONESHOT  = 1'b0;
    localparam logic C_MODE_PERIODIC = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    state_t           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q,   mode_d;
    logic             tick_q,   tick_d;
    logic             done_q,   done_d;

    // A start with a zero period is never accepted; in RUN it acts as stop.
    logic             period_ok;
    // High in the cycle a start is accepted and the run (re)loads.
    logic             load;

    assign period_ok = (period_i != C_ZERO);

    // ------------------------------------------------------------------------
    // Next-state decode: IDLE accepts a start, RUN evaluates
    // stop > start > pause > decrement > terminal count in that priority.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        load     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // stop_i is meaningless here; only a valid start leaves IDLE
                if (start_i && period_ok) begin
                    load = 1'b1;
                end
            end

            S_RUN: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                    count_d = C_ZERO;
                end else if (start_i) begin
                    // restart suppresses any tick that would have fallen on
                    // this edge; a zero period aborts the run instead
                    if (period_ok) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        count_d = C_ZERO;
                    end
                end else if (en_i) begin
                    if (count_q > C_ONE) begin
                        count_d = count_q - C_ONE;
                    end else begin
                        // terminal count: count is 1 here, never 0 in RUN
                        tick_d = 1'b1;
                        if (mode_q == C_MODE_PERIODIC) begin
                            count_d = reload_q;
                        end else begin
                            count_d = C_ZERO;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                // en_i low: everything holds, tick/done stay 0
            end

            default: begin
                state_d = S_IDLE;
                count_d = C_ZERO;
            end
        endcase

        // Shared load path for start from IDLE and restart from RUN
        if (load) begin
            reload_d = period_i;
            mode_d   = mode_i;
            count_d  = period_i;
            state_d  = S_RUN;
        end
    end

    // ------------------------------------------------------------------------
    // State, count, latched configuration and registered pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= S_IDLE;
            count_q  <= C_ZERO;
            reload_q <= C_ZERO;
            mode_q   <= C_MODE_ONESHOT;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    assign busy_o  = (state_q == S_RUN);
    assign tick_o  = tick_q;
    assign done_o  = done_q;
    assign count_o = count_q;

`ifdef TICK_GEN_TICK_CNT_EN
    // ------------------------------------------------------------------------
    // Tick counter: cleared on accepted start, saturates at all-ones, and
    // keeps its value through stop and IDLE.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] tick_cnt_q, tick_cnt_d;

    // Clear on load, otherwise step with each tick until saturated
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (load) begin
            tick_cnt_d = C_ZERO;
        end else if (tick_d && (tick_cnt_q != {WIDTH{1'b1}})) begin
            tick_cnt_d = tick_cnt_q + C_ONE;
        end
    end

    // Register the tick count alongside the tick pulse it counts
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            tick_cnt_q <= C_ZERO;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign tick_cnt_o = tick_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_gen
//  Purpose  : Self-checking bench for tick_gen. Directed scenarios followed by
//             random control traffic, all checked against a model that tracks
//             the number of enabled cycles elapsed since the last start.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tick_gen;

    localparam int WIDTH = 8;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             arst = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic [WIDTH-1:0] period = '0;
    logic             busy;
    logic             tick;
    logic             done;
    logic [WIDTH-1:0] count;
`ifdef TICK_GEN_TICK_CNT_EN
    logic [WIDTH-1:0] tick_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a run is described by its period N, its mode and the
    // number of enabled cycles e elapsed since it started.
    bit m_busy = 0;
    int m_n    = 0;
    bit m_mode = 0;
    int m_e    = 0;
    bit m_tick = 0;
    bit m_done = 0;
    int m_tcnt = 0;
    int ticks_seen = 0;

    tick_gen #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk),
        .arst_i     (arst),
        .start_i    (start),
        .stop_i     (stop),
        .en_i       (en),
        .mode_i     (mode),
        .period_i   (period),
        .busy_o     (busy),
        .tick_o     (tick),
        .done_o     (done),
        .count_o    (count)
`ifdef TICK_GEN_TICK_CNT_EN
        ,
        .tick_cnt_o (tick_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        if (!m_busy)      return 0;
        else if (m_mode)  return m_n - (m_e % m_n);
        else              return m_n - m_e;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_n = 0; m_mode = 0; m_e = 0;
        m_tick = 0; m_done = 0; m_tcnt = 0;
    endtask

    // Advance the model by one clock edge using the inputs presented to it
    task automatic model_edge();
        m_tick = 0;
        m_done = 0;
        if (!m_busy) begin
            if (start && period != 0) begin
                m_busy = 1; m_n = int'(period); m_mode = mode; m_e = 0; m_tcnt = 0;
            end
        end else if (stop) begin
            m_busy = 0;
        end else if (start) begin
            if (period != 0) begin
                m_n = int'(period); m_mode = mode; m_e = 0; m_tcnt = 0;
            end else begin
                m_busy = 0;
            end
        end else if (en) begin
            m_e++;
            if (m_mode) begin
                if (m_e % m_n == 0) m_tick = 1;
            end else if (m_e == m_n) begin
                m_tick = 1; m_done = 1; m_busy = 0;
            end
        end
        if (m_tick && m_tcnt < MAXV) m_tcnt++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"},  32'(busy),  32'(m_busy));
        chk({tag, ".tick"},  32'(tick),  32'(m_tick));
        chk({tag, ".done"},  32'(done),  32'(m_done));
        chk({tag, ".count"}, 32'(count), 32'(model_count()));
`ifdef TICK_GEN_TICK_CNT_EN
        chk({tag, ".tick_cnt"}, 32'(tick_cnt), 32'(m_tcnt));
`endif
    endtask

    // One clock: drive on the falling edge, check 1 ns after the rising edge
    task automatic step(input string tag, input bit s, input bit p, input bit e,
                        input bit md, input int per);
        @(negedge clk);
        start  = s;
        stop   = p;
        en     = e;
        mode   = md;
        period = WIDTH'(per);
        @(posedge clk);
        model_edge();
        #1;
        if (tick) ticks_seen++;
        check_all(tag);
    endtask

    task automatic idle_steps(input string tag, input int n, input bit e);
        for (int i = 0; i < n; i++) step(tag, 0, 0, e, 0, 0);
    endtask

    initial begin
        // ---- reset state ----
        arst = 1'b1;
        #12;
        chk("reset.busy",  32'(busy),  0);
        chk("reset.tick",  32'(tick),  0);
        chk("reset.done",  32'(done),  0);
        chk("reset.count", 32'(count), 0);
        @(negedge clk);
        arst = 1'b0;
        model_reset();

        // ---- reset mid-run: period 10, count down to 4, then reset ----
        step("rst_run.start", 1, 0, 1, 1, 10);
        idle_steps("rst_run.cnt", 6, 1);
        chk("rst_run.pre_count", 32'(count), 4);
        @(negedge clk);
        arst = 1'b1;
        #1;
        model_reset();
        chk("rst_run.busy",  32'(busy),  0);
        chk("rst_run.count", 32'(count), 0);
        chk("rst_run.tick",  32'(tick),  0);
        @(negedge clk);
        arst = 1'b0;
        ticks_seen = 0;
        idle_steps("rst_run.after", 20, 1);
        chk("rst_run.no_tick", 32'(ticks_seen), 0);

        // ---- one-shot period 5 ----
        step("oneshot.start", 1, 0, 1, 0, 5);
        idle_steps("oneshot.run", 4, 1);
        chk("oneshot.pre_tick", 32'(tick), 0);
        step("oneshot.term", 0, 0, 1, 0, 0);
        chk("oneshot.tick", 32'(tick), 1);
        chk("oneshot.done", 32'(done), 1);
        step("oneshot.after", 0, 0, 1, 0, 0);
        chk("oneshot.busy_low", 32'(busy), 0);

        // ---- periodic period 3, 12 enabled cycles -> 4 ticks ----
        step("per3.start", 1, 0, 1, 1, 3);
        ticks_seen = 0;
        idle_steps("per3.run", 12, 1);
        chk("per3.ticks", 32'(ticks_seen), 4);
        // pause of 2 cycles just before a tick delays it by 2
        step("per3b.start", 1, 0, 1, 1, 3);
        idle_steps("per3b.a", 4, 1);
        idle_steps("per3b.pause", 2, 0);
        step("per3b.c7", 0, 0, 1, 1, 0);
        chk("per3b.no_tick7", 32'(tick), 0);
        step("per3b.c8", 0, 0, 1, 1, 0);
        chk("per3b.tick8", 32'(tick), 1);

        // ---- stop at terminal count ----
        step("stopterm.start", 1, 0, 1, 0, 2);
        step("stopterm.dec", 0, 0, 1, 0, 0);
        step("stopterm.stop", 0, 1, 1, 0, 0);
        chk("stopterm.tick", 32'(tick), 0);
        chk("stopterm.busy", 32'(busy), 0);
        // ---- zero-period start ignored ----
        step("zero.start", 1, 0, 1, 1, 0);
        chk("zero.busy", 32'(busy), 0);

        // ---- restart in periodic run ----
        step("restart.start", 1, 0, 1, 1, 8);
        idle_steps("restart.run", 6, 1);
        step("restart.new", 1, 0, 1, 1, 4);
        step("restart.old_boundary", 0, 0, 1, 1, 0);
        idle_steps("restart.run2", 2, 1);
        step("restart.tick", 0, 0, 1, 1, 0);
        chk("restart.tick4", 32'(tick), 1);

        // ---- period 1 periodic: tick every enabled cycle ----
        step("per1.start", 1, 0, 1, 1, 1);
        ticks_seen = 0;
        idle_steps("per1.run", 260, 1);
        chk("per1.ticks", 32'(ticks_seen), 260);
        step("per1.restart", 1, 0, 1, 1, 2);
        step("per1.stop", 0, 1, 0, 0, 0);

        // ---- random traffic ----
        for (int i = 0; i < 1500; i++) begin
            bit s, p, e, md;
            int per;
            s   = ($urandom_range(0, 15) == 0);
            p   = ($urandom_range(0, 40) == 0);
            e   = ($urandom_range(0, 3) != 0);
            md  = 1'($urandom_range(0, 1));
            per = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MAXV))
                                              : int'($urandom_range(0, 6));
            step("rand", s, p, e, md, per);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the bench always ends on its own
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
